// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: steps one instruction at a time through the
// core's stages. Optional perf counters are enabled with STAGE_SEQ_PERF_EN.
module stage_sequencer #(
    parameter int IF_WAIT_CYCLES  = 1,
    parameter int MEM_WAIT_CYCLES = 1,
    parameter int CNT_W           = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        skip_mem,
    input  logic        halt,
    output logic        pc_wren,
    output logic        if_id_wren,
    output logic        id_ex_wren,
    output logic        ex_mem_wren,
    output logic        mem_wb_wren,
    output logic        ram_wren,
    output logic        reg_wren,
    output logic        stage_reset_n,
    output logic [3:0]  stage,
    output logic        halted
`ifdef STAGE_SEQ_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] cycles
`endif
);

    generate
        if (IF_WAIT_CYCLES < 1 || IF_WAIT_CYCLES > (1 << CNT_W)) begin : g_bad_if_wait
            $error("IF_WAIT_CYCLES out of range 1..2**CNT_W");
        end
        if (MEM_WAIT_CYCLES < 1 || MEM_WAIT_CYCLES > (1 << CNT_W)) begin : g_bad_mem_wait
            $error("MEM_WAIT_CYCLES out of range 1..2**CNT_W");
        end
    endgenerate

    // The counter holds "remaining cycles minus one", so a full 2**CNT_W wait still fits.
    localparam logic [CNT_W-1:0] IF_LOAD  = CNT_W'(IF_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAIT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IF       = 4'd1,
        S_IF_WAIT  = 4'd2,
        S_ID       = 4'd3,
        S_EX       = 4'd4,
        S_MEM      = 4'd5,
        S_MEM_WAIT = 4'd6,
        S_WB       = 4'd7,
        S_HALT     = 4'd8
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             skip_q;
    logic             skip_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_INIT;
            wait_cnt <= '0;
            skip_q   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
            skip_q   <= skip_next;
        end
    end

    always_comb begin
        state_next    = S_INIT;
        cnt_next      = wait_cnt;
        skip_next     = skip_q;
        pc_wren       = 1'b0;
        if_id_wren    = 1'b0;
        id_ex_wren    = 1'b0;
        ex_mem_wren   = 1'b0;
        mem_wb_wren   = 1'b0;
        ram_wren      = 1'b0;
        reg_wren      = 1'b0;
        stage_reset_n = 1'b1;
        halted        = 1'b0;
        case (state)
            S_INIT: begin
                stage_reset_n = 1'b0;
                state_next    = S_IF;
            end
            S_IF: begin
                state_next = S_IF_WAIT;
                cnt_next   = IF_LOAD;
            end
            S_IF_WAIT: begin
                if (wait_cnt == '0) begin
                    if_id_wren = 1'b1;
                    state_next = S_ID;
                end else begin
                    state_next = S_IF_WAIT;
                    cnt_next   = wait_cnt - CNT_W'(1);
                end
            end
            S_ID: begin
                id_ex_wren = 1'b1;
                state_next = S_EX;
            end
            S_EX: begin
                ex_mem_wren = 1'b1;
                state_next  = S_MEM;
                skip_next   = skip_mem;
                // Bypassed instructions spend a single cycle in MEM_WAIT.
                cnt_next    = skip_mem ? '0 : MEM_LOAD;
            end
            S_MEM: begin
                pc_wren    = 1'b1;
                ram_wren   = ~skip_q;
                state_next = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (wait_cnt == '0) begin
                    mem_wb_wren = 1'b1;
                    state_next  = S_WB;
                end else begin
                    state_next = S_MEM_WAIT;
                    cnt_next   = wait_cnt - CNT_W'(1);
                end
            end
            S_WB: begin
                reg_wren      = 1'b1;
                stage_reset_n = 1'b0;
                state_next    = halt ? S_HALT : S_IF;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = halt ? S_HALT : S_IF;
            end
            default: begin
                stage_reset_n = 1'b0;
                state_next    = S_INIT;
            end
        endcase
    end

    assign stage = state;

`ifdef STAGE_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            // WB always leaves to IF or HALT, so every WB edge retires one instruction.
            if (state == S_WB) begin
                retired <= retired + 32'd1;
            end
            if (state != S_INIT && state != S_HALT) begin
                cycles <= cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench: dut_a runs default wait lengths, dut_b runs IF_WAIT=3 / MEM_WAIT=2.
module tb_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic skip_a  = 1'b0;
    logic halt_a  = 1'b0;
    logic skip_b  = 1'b0;
    logic halt_b  = 1'b0;

    logic       pc_a, ifid_a, idex_a, exmem_a, memwb_a, ram_a, reg_a, srn_a, halted_a;
    logic [3:0] stage_a;
    logic       pc_b, ifid_b, idex_b, exmem_b, memwb_b, ram_b, reg_b, srn_b, halted_b;
    logic [3:0] stage_b;
`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] retired_a, cycles_a, retired_b, cycles_b;
`endif

    // Output vector bit order: pc, if_id, id_ex, ex_mem, mem_wb, ram, reg, stage_reset_n
    logic [7:0] outs_a, outs_b;
    assign outs_a = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, ram_a, reg_a, srn_a};
    assign outs_b = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, ram_b, reg_b, srn_b};

    stage_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .skip_mem(skip_a), .halt(halt_a),
        .pc_wren(pc_a), .if_id_wren(ifid_a), .id_ex_wren(idex_a),
        .ex_mem_wren(exmem_a), .mem_wb_wren(memwb_a), .ram_wren(ram_a),
        .reg_wren(reg_a), .stage_reset_n(srn_a), .stage(stage_a), .halted(halted_a)
`ifdef STAGE_SEQ_PERF_EN
        , .retired(retired_a), .cycles(cycles_a)
`endif
    );

    stage_sequencer #(.IF_WAIT_CYCLES(3), .MEM_WAIT_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .skip_mem(skip_b), .halt(halt_b),
        .pc_wren(pc_b), .if_id_wren(ifid_b), .id_ex_wren(idex_b),
        .ex_mem_wren(exmem_b), .mem_wb_wren(memwb_b), .ram_wren(ram_b),
        .reg_wren(reg_b), .stage_reset_n(srn_b), .stage(stage_b), .halted(halted_b)
`ifdef STAGE_SEQ_PERF_EN
        , .retired(retired_b), .cycles(cycles_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Hand-derived per-cycle expectations, starting at the IF cycle.
    logic [3:0] seq_a  [7]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [7:0] out_a  [7]  = '{8'h01, 8'h41, 8'h21, 8'h11, 8'h85, 8'h09, 8'h02};
    logic [3:0] seq_b  [10] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7};
    logic [7:0] out_b  [10] = '{8'h01, 8'h01, 8'h01, 8'h41, 8'h21, 8'h11, 8'h85, 8'h01, 8'h09, 8'h02};
    logic [3:0] seq_bs [9]  = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [7:0] out_bs [9]  = '{8'h01, 8'h01, 8'h01, 8'h41, 8'h21, 8'h11, 8'h81, 8'h09, 8'h02};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses reset and returns sampled in the first IF cycle.
    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        total++; if (stage_a !== 4'd0) begin bad++; $display("FAIL reset_stage_a got=%0d exp=0", stage_a); end
        total++; if (outs_a !== 8'h00) begin bad++; $display("FAIL reset_outs_a got=%h exp=00", outs_a); end
        total++; if (halted_a !== 1'b0) begin bad++; $display("FAIL reset_halted_a got=%b exp=0", halted_a); end
        total++; if (stage_b !== 4'd0) begin bad++; $display("FAIL reset_stage_b got=%0d exp=0", stage_b); end
        total++; if (outs_b !== 8'h00) begin bad++; $display("FAIL reset_outs_b got=%h exp=00", outs_b); end
`ifdef STAGE_SEQ_PERF_EN
        total++; if (retired_a !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired_a); end
        total++; if (cycles_a !== 32'd0) begin bad++; $display("FAIL reset_cycles got=%0d exp=0", cycles_a); end
`endif
        reset_n = 1'b1;
        tick();
        total++; if (stage_a !== 4'd1) begin bad++; $display("FAIL reset_release_a got=%0d exp=1", stage_a); end
        total++; if (stage_b !== 4'd1) begin bad++; $display("FAIL reset_release_b got=%0d exp=1", stage_b); end
    endtask

    task automatic test_default;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            total++; if (stage_a !== seq_a[k % 7]) begin bad++; $display("FAIL default_stage k=%0d got=%0d exp=%0d", k, stage_a, seq_a[k % 7]); end
            total++; if (outs_a !== out_a[k % 7]) begin bad++; $display("FAIL default_outs k=%0d got=%h exp=%h", k, outs_a, out_a[k % 7]); end
            total++; if (halted_a !== 1'b0) begin bad++; $display("FAIL default_halted k=%0d got=%b exp=0", k, halted_a); end
            tick();
        end
        total++; if (stage_a !== 4'd1) begin bad++; $display("FAIL default_wrap got=%0d exp=1", stage_a); end
    endtask

    // skip_mem is held high everywhere except EX, so it must be ignored.
    task automatic test_long_wait;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            total++; if (stage_b !== seq_b[i]) begin bad++; $display("FAIL long_stage i=%0d got=%0d exp=%0d", i, stage_b, seq_b[i]); end
            total++; if (outs_b !== out_b[i]) begin bad++; $display("FAIL long_outs i=%0d got=%h exp=%h", i, outs_b, out_b[i]); end
            skip_b = (i != 5);
            tick();
        end
        skip_b = 1'b0;
        total++; if (stage_b !== 4'd1) begin bad++; $display("FAIL long_period got=%0d exp=1", stage_b); end
    endtask

    task automatic test_skip_mem;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            total++; if (stage_b !== seq_bs[i]) begin bad++; $display("FAIL skip_stage i=%0d got=%0d exp=%0d", i, stage_b, seq_bs[i]); end
            total++; if (outs_b !== out_bs[i]) begin bad++; $display("FAIL skip_outs i=%0d got=%h exp=%h", i, outs_b, out_bs[i]); end
            skip_b = (i == 5);
            tick();
        end
        skip_b = 1'b0;
        total++; if (stage_b !== 4'd1) begin bad++; $display("FAIL skip_period got=%0d exp=1", stage_b); end
        // The next instruction must go back to the full memory wait.
        for (int i = 0; i < 10; i++) begin
            total++; if (outs_b !== out_b[i]) begin bad++; $display("FAIL skip_after_outs i=%0d got=%h exp=%h", i, outs_b, out_b[i]); end
            tick();
        end
    endtask

    task automatic test_halt;
        do_reset();
        halt_a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            total++; if (stage_a !== seq_a[i]) begin bad++; $display("FAIL halt_pre_stage i=%0d got=%0d exp=%0d", i, stage_a, seq_a[i]); end
            total++; if (outs_a !== out_a[i]) begin bad++; $display("FAIL halt_pre_outs i=%0d got=%h exp=%h", i, outs_a, out_a[i]); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (stage_a !== 4'd8) begin bad++; $display("FAIL halt_stage i=%0d got=%0d exp=8", i, stage_a); end
            total++; if (outs_a !== 8'h01) begin bad++; $display("FAIL halt_outs i=%0d got=%h exp=01", i, outs_a); end
            total++; if (halted_a !== 1'b1) begin bad++; $display("FAIL halt_halted i=%0d got=%b exp=1", i, halted_a); end
            tick();
        end
        halt_a = 1'b0;
        tick();
        total++; if (halted_a !== 1'b0) begin bad++; $display("FAIL resume_halted got=%b exp=0", halted_a); end
        for (int i = 0; i < 7; i++) begin
            total++; if (stage_a !== seq_a[i]) begin bad++; $display("FAIL resume_stage i=%0d got=%0d exp=%0d", i, stage_a, seq_a[i]); end
            total++; if (outs_a !== out_a[i]) begin bad++; $display("FAIL resume_outs i=%0d got=%h exp=%h", i, outs_a, out_a[i]); end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        total++; if (stage_b !== 4'd6) begin bad++; $display("FAIL mid_pre_stage got=%0d exp=6", stage_b); end
        reset_n = 1'b0;
        #1;
        total++; if (stage_b !== 4'd0) begin bad++; $display("FAIL mid_async_stage got=%0d exp=0", stage_b); end
        total++; if (outs_b !== 8'h00) begin bad++; $display("FAIL mid_async_outs got=%h exp=00", outs_b); end
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            total++; if (stage_b !== seq_b[i]) begin bad++; $display("FAIL mid_after_stage i=%0d got=%0d exp=%0d", i, stage_b, seq_b[i]); end
            total++; if (outs_b !== out_b[i]) begin bad++; $display("FAIL mid_after_outs i=%0d got=%h exp=%h", i, outs_b, out_b[i]); end
            tick();
        end
    endtask

`ifdef STAGE_SEQ_PERF_EN
    task automatic test_perf;
        do_reset();
        total++; if (cycles_a !== 32'd0) begin bad++; $display("FAIL perf_start_cycles got=%0d exp=0", cycles_a); end
        for (int i = 0; i < 21; i++) tick();
        total++; if (retired_a !== 32'd3) begin bad++; $display("FAIL perf_retired got=%0d exp=3", retired_a); end
        total++; if (cycles_a !== 32'd21) begin bad++; $display("FAIL perf_cycles_if got=%0d exp=21", cycles_a); end
        tick();
        total++; if (cycles_a !== 32'd22) begin bad++; $display("FAIL perf_cycles got=%0d exp=22", cycles_a); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default();
        test_long_wait();
        test_skip_mem();
        test_halt();
        test_reset_mid();
`ifdef STAGE_SEQ_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
